// File: rtl/writeback_arbiter_pkg.sv
// Shared helpers for the writeback arbiter: round-robin index arithmetic
// used by both the priority encoder and the pointer update.
package writeback_arbiter_pkg;

  localparam int DEFAULT_NUM_UNITS  = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ID_WIDTH   = 3;

  // (base + off) modulo n, for 0 <= base, off < n; avoids a real divider.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

  // Pointer value that gives the unit after idx top priority next time.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/writeback_arbiter_rr_priority_encoder.sv
// Combinational round-robin find-first: searches i_req starting at i_ptr,
// wrapping at NUM_UNITS-1, and returns a one-hot grant plus its index.
module rr_priority_encoder
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_UNITS = DEFAULT_NUM_UNITS,
  parameter int UNIT_W    = $clog2(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] i_req,
  input  logic [UNIT_W-1:0]    i_ptr,
  output logic [NUM_UNITS-1:0] o_grant,
  output logic [UNIT_W-1:0]    o_index,
  output logic                 o_valid
);

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned; otherwise synthesis would infer latches.
  always_comb begin
    int w_idx;
    o_grant = '0;
    o_index = '0;
    o_valid = 1'b0;
    // Walk from the farthest offset back toward i_ptr so the last hit,
    // which wins, is the first requester in rotation order.
    for (int off = NUM_UNITS - 1; off >= 0; off--) begin
      w_idx = rr_wrap(int'(i_ptr), off, NUM_UNITS);
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_index = UNIT_W'(w_idx);
      end
    end
    o_grant[o_index] = o_valid;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: acks one completed unit per cycle and
// registers its id/result as a single commit toward the register file.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_UNITS  = DEFAULT_NUM_UNITS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = DEFAULT_ID_WIDTH,
  parameter int UNIT_W     = $clog2(NUM_UNITS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_UNITS-1:0]                 i_unit_done,
  input  logic [NUM_UNITS-1:0][ID_WIDTH-1:0]   i_unit_id,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] i_unit_rd,
  output logic [NUM_UNITS-1:0]                 o_unit_ack,
  input  logic                                 i_wb_stall,
  output logic                                 o_wb_valid,
  output logic [ID_WIDTH-1:0]                  o_wb_id,
  output logic [DATA_WIDTH-1:0]                o_wb_data,
  output logic [UNIT_W-1:0]                    o_wb_unit
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
  } commit_t;

  logic [UNIT_W-1:0]    r_ptr;
  logic                 r_wb_valid;
  commit_t              r_commit;
  logic [UNIT_W-1:0]    r_wb_unit;

  logic [NUM_UNITS-1:0] w_grant;
  logic [UNIT_W-1:0]    w_index;
  logic                 w_any;
  logic                 w_fire;

  rr_priority_encoder #(
    .NUM_UNITS (NUM_UNITS),
    .UNIT_W    (UNIT_W)
  ) u_rr (
    .i_req   (i_unit_done),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_index (w_index),
    .o_valid (w_any)
  );

  // Reset gates the ack too, so a unit never sees an ack for a commit
  // that the reset is about to discard.
  assign w_fire     = w_any & ~i_wb_stall & ~rst;
  assign o_unit_ack = w_grant & {NUM_UNITS{w_fire}};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_wb_valid <= 1'b0;
      r_commit   <= '0;
      r_wb_unit  <= '0;
    end else begin
      r_wb_valid <= w_fire;
      if (w_fire) begin
        r_ptr         <= UNIT_W'(rr_next(int'(w_index), NUM_UNITS));
        r_commit.id   <= i_unit_id[w_index];
        r_commit.data <= i_unit_rd[w_index];
        r_wb_unit     <= w_index;
      end
    end
  end

  assign o_wb_valid = r_wb_valid;
  assign o_wb_id    = r_commit.id;
  assign o_wb_data  = r_commit.data;
  assign o_wb_unit  = r_wb_unit;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: stepped vector table, hand-written reset and
// wrap sequences, then randomized traffic against a queue-free rotation model.
module tb_writeback_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int UW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         done;
  logic [N-1:0][IW-1:0] ids;
  logic [N-1:0][DW-1:0] rds;
  logic [N-1:0]         ack;
  logic                 stall;
  logic                 wb_valid;
  logic [IW-1:0]        wb_id;
  logic [DW-1:0]        wb_data;
  logic [UW-1:0]        wb_unit;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .NUM_UNITS  (N),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_unit_done (done),
    .i_unit_id   (ids),
    .i_unit_rd   (rds),
    .o_unit_ack  (ack),
    .i_wb_stall  (stall),
    .o_wb_valid  (wb_valid),
    .o_wb_id     (wb_id),
    .o_wb_data   (wb_data),
    .o_wb_unit   (wb_unit)
  );

  typedef struct {
    logic [N-1:0]  done;
    logic          stall;
    logic [N-1:0]  ack;
    logic          valid;
    logic [UW-1:0] unit;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; combinational ack is sampled 1ns later.
  task automatic drive(input logic [N-1:0] d, input logic s);
    @(negedge clk);
    done  = d;
    stall = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    done = '0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset wb_valid", 64'(wb_valid), 64'd0);
    check("reset ack", 64'(ack), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_fixed_payload();
    for (int u = 0; u < N; u++) begin
      ids[u] = IW'(u + 4);
      rds[u] = DW'(32'h100 + u);
    end
  endtask

  // Randomized-phase model state.
  int           ptr_m;
  int           wait_cnt [N];
  logic [N-1:0] last_ack;

  initial begin
    rst   = 1'b1;
    done  = '0;
    stall = 1'b0;
    set_fixed_payload();

    // Stepped table from a fresh reset (pointer at 0).
    for (int i = 0; i < 5; i++) vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});
    vecs.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0});
    vecs.push_back('{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1});
    vecs.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2});
    vecs.push_back('{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3});
    vecs.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0});
    for (int i = 0; i < 3; i++) vecs.push_back('{4'b1010, 1'b1, 4'b0000, 1'b0, 2'd0});
    vecs.push_back('{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1});
    vecs.push_back('{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3});
    vecs.push_back('{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0});
    vecs.push_back('{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].done, vecs[i].stall);
      check($sformatf("vec%0d ack", i), 64'(ack), 64'(vecs[i].ack));
      tick();
      check($sformatf("vec%0d wb_valid", i), 64'(wb_valid), 64'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d wb_unit", i), 64'(wb_unit), 64'(vecs[i].unit));
        check($sformatf("vec%0d wb_id", i), 64'(wb_id), 64'(vecs[i].unit + 4));
        check($sformatf("vec%0d wb_data", i), 64'(wb_data), 64'(32'h100 + vecs[i].unit));
      end
    end

    // Single request: unit 2, id 5, data 0xAA; commit then hold.
    do_reset();
    ids[2] = 3'd5;
    rds[2] = 32'h0000_00AA;
    drive(4'b0100, 1'b0);
    check("single ack", 64'(ack), 64'b0100);
    tick();
    check("single wb_valid", 64'(wb_valid), 64'd1);
    check("single wb_id", 64'(wb_id), 64'd5);
    check("single wb_data", 64'(wb_data), 64'hAA);
    check("single wb_unit", 64'(wb_unit), 64'd2);
    drive(4'b0000, 1'b0);
    tick();
    check("idle wb_valid", 64'(wb_valid), 64'd0);
    check("idle wb_id hold", 64'(wb_id), 64'd5);
    check("idle wb_data hold", 64'(wb_data), 64'hAA);
    set_fixed_payload();

    // Reset with a commit in flight: pointer must return to 0.
    do_reset();
    drive(4'b0101, 1'b0);
    check("pre-rst ack", 64'(ack), 64'b0001);
    tick();
    check("pre-rst wb_valid", 64'(wb_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst ack gate", 64'(ack), 64'd0);
    tick();
    check("rst wb_valid", 64'(wb_valid), 64'd0);
    check("rst wb_unit", 64'(wb_unit), 64'd0);
    check("rst wb_id", 64'(wb_id), 64'd0);
    check("rst wb_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst ptr0 ack", 64'(ack), 64'b0001);
    tick();
    check("post-rst wb_unit", 64'(wb_unit), 64'd0);

    // Randomized traffic: units hold done until acked and may reissue at once.
    do_reset();
    ptr_m    = 0;
    last_ack = '0;
    for (int u = 0; u < N; u++) wait_cnt[u] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [N-1:0]  d;
      logic [N-1:0]  exp_ack;
      logic          exp_valid;
      logic [IW-1:0] exp_id;
      logic [DW-1:0] exp_data;
      int            exp_unit;
      @(negedge clk);
      d = done;
      for (int u = 0; u < N; u++) begin
        if (!d[u] || last_ack[u]) begin
          d[u] = ($urandom_range(0, 2) == 0);
          if (d[u]) begin
            ids[u] = IW'($urandom);
            rds[u] = $urandom;
          end
        end
      end
      done  = d;
      stall = ($urandom_range(0, 5) == 0);
      #1;
      exp_ack   = '0;
      exp_valid = 1'b0;
      exp_unit  = 0;
      exp_id    = '0;
      exp_data  = '0;
      if (!stall) begin
        for (int off = 0; off < N; off++) begin
          int k;
          k = (ptr_m + off) % N;
          if (!exp_valid && done[k]) begin
            exp_valid = 1'b1;
            exp_unit  = k;
          end
        end
      end
      if (exp_valid) begin
        exp_ack[exp_unit] = 1'b1;
        exp_id   = ids[exp_unit];
        exp_data = rds[exp_unit];
        ptr_m    = (exp_unit + 1) % N;
      end
      check($sformatf("rand%0d ack", cyc), 64'(ack), 64'(exp_ack));
      for (int u = 0; u < N; u++) begin
        if (!done[u] || ack[u]) wait_cnt[u] = 0;
        else if (!stall) wait_cnt[u]++;
        if (wait_cnt[u] >= N)
          check($sformatf("rand%0d fairness u%0d", cyc, u), 64'(wait_cnt[u]), 64'(N - 1));
      end
      last_ack = ack;
      tick();
      check($sformatf("rand%0d wb_valid", cyc), 64'(wb_valid), 64'(exp_valid));
      if (exp_valid) begin
        check($sformatf("rand%0d wb_unit", cyc), 64'(wb_unit), 64'(exp_unit));
        check($sformatf("rand%0d wb_id", cyc), 64'(wb_id), 64'(exp_id));
        check($sformatf("rand%0d wb_data", cyc), 64'(wb_data), 64'(exp_data));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
